// File: rtl/hazard_ctrl_if.sv
// Bundles the pipeline status seen by the hazard controller with the stall,
// flush and redirect controls it returns to the stage registers.
interface hazard_ctrl_if;
  logic [4:0]  i_id_Rs1;
  logic [4:0]  i_id_Rs2;
  logic        i_id_UsesRs1;
  logic        i_id_UsesRs2;
  logic [4:0]  i_ex_RegDst;
  logic        i_ex_MemToReg;
  logic        i_ex_RegWrEn;
  logic        i_ex_Redirect;
  logic        i_mem_Req;
  logic        i_mem_Ready;
  logic        o_if_stall;
  logic        o_id_stall;
  logic        o_ex_stall;
  logic        o_mem_stall;
  logic        o_if_flush;
  logic        o_id_flush;
  logic        o_pc_sel;
  logic        o_mem_timeout;
  logic [15:0] o_stall_cnt;

  modport master (
    output i_id_Rs1, i_id_Rs2, i_id_UsesRs1, i_id_UsesRs2,
           i_ex_RegDst, i_ex_MemToReg, i_ex_RegWrEn, i_ex_Redirect,
           i_mem_Req, i_mem_Ready,
    input  o_if_stall, o_id_stall, o_ex_stall, o_mem_stall,
           o_if_flush, o_id_flush, o_pc_sel, o_mem_timeout, o_stall_cnt
  );

  modport slave (
    input  i_id_Rs1, i_id_Rs2, i_id_UsesRs1, i_id_UsesRs2,
           i_ex_RegDst, i_ex_MemToReg, i_ex_RegWrEn, i_ex_Redirect,
           i_mem_Req, i_mem_Ready,
    output o_if_stall, o_id_stall, o_ex_stall, o_mem_stall,
           o_if_flush, o_id_flush, o_pc_sel, o_mem_timeout, o_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, redirect flushes and
// load-use bubbles, with a sticky memory-timeout flag and a stall counter.
module hazard_ctrl #(
  parameter int FLUSH_LEN   = 2,
  parameter int MEM_TIMEOUT = 255
) (
  input logic          clk,
  input logic          reset_n,
  hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

  localparam logic [2:0]  FLUSH_RELOAD = 3'(FLUSH_LEN - 1);
  localparam logic [15:0] TIMEOUT_VAL  = 16'(MEM_TIMEOUT);
  localparam logic [15:0] SAT          = 16'hFFFF;

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_nxt;
  logic [15:0] stall_cnt;
  logic [2:0]  flush_cnt, flush_nxt;
  logic        timeout_flag;
  logic        load_use, mem_block;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, pc_sel;

  assign mem_block = bus.i_mem_Req & ~bus.i_mem_Ready;
  assign load_use  = bus.i_ex_MemToReg & bus.i_ex_RegWrEn & (bus.i_ex_RegDst != 5'd0) &
                     ((bus.i_id_UsesRs1 & (bus.i_id_Rs1 == bus.i_ex_RegDst)) |
                      (bus.i_id_UsesRs2 & (bus.i_id_Rs2 == bus.i_ex_RegDst)));

  // Controls are gated by reset_n so they drop the instant reset asserts.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    flush_nxt = flush_cnt;
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    if_flush  = 1'b0;
    id_flush  = 1'b0;
    pc_sel    = 1'b0;
    if (reset_n) begin
      case (state)
        RUN, FLUSH: begin
          if (mem_block) begin
            {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
            state_nxt = MEM_WAIT;
            wait_nxt  = 16'd1;
          end else if (bus.i_ex_Redirect) begin
            pc_sel   = 1'b1;
            if_flush = 1'b1;
            id_flush = 1'b1;
            if (FLUSH_LEN > 1) begin
              state_nxt = FLUSH;
              flush_nxt = FLUSH_RELOAD;
            end
          end else if (state == FLUSH) begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            flush_nxt = flush_cnt - 3'd1;
            if (flush_cnt <= 3'd1) state_nxt = RUN;
          end else if (load_use) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
            id_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (mem_block) begin
            {if_stall, id_stall, ex_stall, mem_stall} = 4'b1111;
            if (wait_cnt != SAT) wait_nxt = wait_cnt + 16'd1;
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      wait_cnt     <= 16'd0;
      flush_cnt    <= 3'd0;
      timeout_flag <= 1'b0;
      stall_cnt    <= 16'd0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      flush_cnt <= flush_nxt;
      if (wait_nxt >= TIMEOUT_VAL) timeout_flag <= 1'b1;
      if ((id_stall | id_flush) && stall_cnt != SAT) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.o_if_stall    = if_stall;
  assign bus.o_id_stall    = id_stall;
  assign bus.o_ex_stall    = ex_stall;
  assign bus.o_mem_stall   = mem_stall;
  assign bus.o_if_flush    = if_flush;
  assign bus.o_id_flush    = id_flush;
  assign bus.o_pc_sel      = pc_sel;
  assign bus.o_mem_timeout = timeout_flag;
  assign bus.o_stall_cnt   = stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_LEN=2, MEM_TIMEOUT=4): each scenario
// drives hand-built vectors and compares outputs against hand-computed values.
module tb_hazard_ctrl;
  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;
  logic [15:0] exp_cnt;
  logic [6:0]  ctl;

  // ctl = {pc_sel, if_flush, id_flush, if_stall, id_stall, ex_stall, mem_stall}
  localparam logic [6:0] C_NONE  = 7'b000_0000;
  localparam logic [6:0] C_ALL   = 7'b000_1111;
  localparam logic [6:0] C_LU    = 7'b001_1100;
  localparam logic [6:0] C_REDIR = 7'b111_0000;
  localparam logic [6:0] C_FLUSH = 7'b011_0000;

  typedef struct packed {
    logic       red;
    logic       req;
    logic       rdy;
    logic       lu;
    logic       to;
    logic [6:0] exp;
  } seq_t;

  hazard_ctrl_if hif();

  hazard_ctrl #(.FLUSH_LEN(2), .MEM_TIMEOUT(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (hif)
  );

  assign ctl = {hif.o_pc_sel, hif.o_if_flush, hif.o_id_flush,
                hif.o_if_stall, hif.o_id_stall, hif.o_ex_stall, hif.o_mem_stall};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic seq_t mk(input logic red, req, rdy, lu, to, input logic [6:0] e);
    return '{red: red, req: req, rdy: rdy, lu: lu, to: to, exp: e};
  endfunction

  task automatic set_idle();
    hif.i_id_Rs1 = 5'd0;       hif.i_id_Rs2 = 5'd0;
    hif.i_id_UsesRs1 = 1'b0;   hif.i_id_UsesRs2 = 1'b0;
    hif.i_ex_RegDst = 5'd0;    hif.i_ex_MemToReg = 1'b0;
    hif.i_ex_RegWrEn = 1'b0;   hif.i_ex_Redirect = 1'b0;
    hif.i_mem_Req = 1'b0;      hif.i_mem_Ready = 1'b0;
  endtask

  // Load in EX writing dst; ID reads dst through Rs2 only.
  task automatic set_lu(input logic [4:0] dst);
    hif.i_ex_MemToReg = 1'b1;  hif.i_ex_RegWrEn = 1'b1;
    hif.i_ex_RegDst = dst;     hif.i_id_Rs2 = dst;
    hif.i_id_UsesRs2 = 1'b1;   hif.i_id_Rs1 = dst + 5'd1;
    hif.i_id_UsesRs1 = 1'b1;
  endtask

  task automatic apply_row(input seq_t r);
    set_idle();
    hif.i_ex_Redirect = r.red;
    hif.i_mem_Req     = r.req;
    hif.i_mem_Ready   = r.rdy;
    if (r.lu) set_lu(5'd5);
  endtask

  task automatic bump(input logic [6:0] e);
    if ((e[4] | e[2]) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_idle();
    set_lu(5'd5);
    hif.i_ex_Redirect = 1'b1;
    #3;
    vectors++;
    if (ctl !== C_NONE) begin miscompares++; $display("[TB] FAIL reset_ctl: got %b want %b", ctl, C_NONE); end
    vectors++;
    if (hif.o_stall_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_cnt: got %h want 0000", hif.o_stall_cnt); end
    vectors++;
    if (hif.o_mem_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_timeout: got %b want 0", hif.o_mem_timeout); end
    repeat (2) next_cycle();
    vectors++;
    if (ctl !== C_NONE) begin miscompares++; $display("[TB] FAIL reset_hold_ctl: got %b want %b", ctl, C_NONE); end
    set_idle();
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    vectors++;
    if (ctl !== C_NONE) begin miscompares++; $display("[TB] FAIL reset_release_ctl: got %b want %b", ctl, C_NONE); end
    vectors++;
    if (hif.o_stall_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_release_cnt: got %h want 0000", hif.o_stall_cnt); end
    exp_cnt = 16'd0;
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [4:0] dst [7];
    logic [4:0] rs1 [7];
    logic [4:0] rs2 [7];
    logic [3:0] flg [7];
    logic [6:0] exp [7];
    // flg = {MemToReg, RegWrEn, UsesRs1, UsesRs2}
    dst[0] = 5'd5; rs1[0] = 5'd3; rs2[0] = 5'd5; flg[0] = 4'b1111; exp[0] = C_LU;
    dst[1] = 5'd0; rs1[1] = 5'd0; rs2[1] = 5'd0; flg[1] = 4'b0000; exp[1] = C_NONE;
    dst[2] = 5'd0; rs1[2] = 5'd0; rs2[2] = 5'd0; flg[2] = 4'b1111; exp[2] = C_NONE;
    dst[3] = 5'd7; rs1[3] = 5'd7; rs2[3] = 5'd2; flg[3] = 4'b1110; exp[3] = C_LU;
    dst[4] = 5'd7; rs1[4] = 5'd7; rs2[4] = 5'd2; flg[4] = 4'b1101; exp[4] = C_NONE;
    dst[5] = 5'd9; rs1[5] = 5'd9; rs2[5] = 5'd9; flg[5] = 4'b0111; exp[5] = C_NONE;
    dst[6] = 5'd9; rs1[6] = 5'd9; rs2[6] = 5'd9; flg[6] = 4'b1011; exp[6] = C_NONE;
    for (int i = 0; i < 7; i++) begin
      set_idle();
      hif.i_ex_RegDst = dst[i];  hif.i_id_Rs1 = rs1[i];  hif.i_id_Rs2 = rs2[i];
      {hif.i_ex_MemToReg, hif.i_ex_RegWrEn, hif.i_id_UsesRs1, hif.i_id_UsesRs2} = flg[i];
      @(negedge clk);
      vectors++;
      if (ctl !== exp[i]) begin miscompares++; $display("[TB] FAIL load_use_ctl[%0d]: got %b want %b", i, ctl, exp[i]); end
      vectors++;
      if (hif.o_stall_cnt !== exp_cnt) begin miscompares++; $display("[TB] FAIL load_use_cnt[%0d]: got %0d want %0d", i, hif.o_stall_cnt, exp_cnt); end
      bump(exp[i]);
      next_cycle();
    end
  endtask

  task automatic test_mem_wait();
    seq_t rows [6];
    rows[0] = mk(0, 1, 0, 0, 0, C_ALL);
    rows[1] = mk(0, 1, 0, 0, 0, C_ALL);
    rows[2] = mk(0, 1, 0, 0, 0, C_ALL);
    rows[3] = mk(0, 1, 1, 0, 0, C_NONE);
    rows[4] = mk(0, 0, 0, 1, 0, C_LU);
    rows[5] = mk(0, 0, 0, 0, 0, C_NONE);
    foreach (rows[i]) begin
      apply_row(rows[i]);
      @(negedge clk);
      vectors++;
      if (ctl !== rows[i].exp) begin miscompares++; $display("[TB] FAIL mem_wait_ctl[%0d]: got %b want %b", i, ctl, rows[i].exp); end
      vectors++;
      if (hif.o_mem_timeout !== rows[i].to) begin miscompares++; $display("[TB] FAIL mem_wait_timeout[%0d]: got %b want %b", i, hif.o_mem_timeout, rows[i].to); end
      vectors++;
      if (hif.o_stall_cnt !== exp_cnt) begin miscompares++; $display("[TB] FAIL mem_wait_cnt[%0d]: got %0d want %0d", i, hif.o_stall_cnt, exp_cnt); end
      bump(rows[i].exp);
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    seq_t rows [7];
    rows[0] = mk(1, 0, 0, 0, 0, C_REDIR);
    rows[1] = mk(0, 0, 0, 0, 0, C_FLUSH);
    rows[2] = mk(0, 0, 0, 0, 0, C_NONE);
    rows[3] = mk(1, 0, 0, 0, 0, C_REDIR);
    rows[4] = mk(1, 0, 0, 0, 0, C_REDIR);
    rows[5] = mk(0, 0, 0, 1, 0, C_FLUSH);
    rows[6] = mk(0, 0, 0, 0, 0, C_NONE);
    foreach (rows[i]) begin
      apply_row(rows[i]);
      @(negedge clk);
      vectors++;
      if (ctl !== rows[i].exp) begin miscompares++; $display("[TB] FAIL redirect_ctl[%0d]: got %b want %b", i, ctl, rows[i].exp); end
      vectors++;
      if (hif.o_stall_cnt !== exp_cnt) begin miscompares++; $display("[TB] FAIL redirect_cnt[%0d]: got %0d want %0d", i, hif.o_stall_cnt, exp_cnt); end
      bump(rows[i].exp);
      next_cycle();
    end
  endtask

  task automatic test_priority();
    seq_t rows [10];
    rows[0] = mk(1, 1, 0, 1, 0, C_ALL);
    rows[1] = mk(1, 1, 0, 1, 0, C_ALL);
    rows[2] = mk(1, 1, 1, 1, 0, C_NONE);
    rows[3] = mk(1, 0, 0, 1, 0, C_REDIR);
    rows[4] = mk(0, 0, 0, 0, 0, C_FLUSH);
    rows[5] = mk(0, 0, 0, 0, 0, C_NONE);
    rows[6] = mk(1, 0, 0, 0, 0, C_REDIR);
    rows[7] = mk(0, 1, 0, 0, 0, C_ALL);
    rows[8] = mk(0, 1, 1, 0, 0, C_NONE);
    rows[9] = mk(0, 0, 0, 0, 0, C_NONE);
    foreach (rows[i]) begin
      apply_row(rows[i]);
      @(negedge clk);
      vectors++;
      if (ctl !== rows[i].exp) begin miscompares++; $display("[TB] FAIL priority_ctl[%0d]: got %b want %b", i, ctl, rows[i].exp); end
      vectors++;
      if (hif.o_stall_cnt !== exp_cnt) begin miscompares++; $display("[TB] FAIL priority_cnt[%0d]: got %0d want %0d", i, hif.o_stall_cnt, exp_cnt); end
      bump(rows[i].exp);
      next_cycle();
    end
  endtask

  task automatic test_timeout();
    seq_t rows [8];
    rows[0] = mk(0, 1, 0, 0, 0, C_ALL);
    rows[1] = mk(0, 1, 0, 0, 0, C_ALL);
    rows[2] = mk(0, 1, 0, 0, 0, C_ALL);
    rows[3] = mk(0, 1, 0, 0, 0, C_ALL);
    rows[4] = mk(0, 1, 0, 0, 1, C_ALL);
    rows[5] = mk(0, 1, 0, 0, 1, C_ALL);
    rows[6] = mk(0, 1, 1, 0, 1, C_NONE);
    rows[7] = mk(0, 0, 0, 0, 1, C_NONE);
    foreach (rows[i]) begin
      apply_row(rows[i]);
      @(negedge clk);
      vectors++;
      if (ctl !== rows[i].exp) begin miscompares++; $display("[TB] FAIL timeout_ctl[%0d]: got %b want %b", i, ctl, rows[i].exp); end
      vectors++;
      if (hif.o_mem_timeout !== rows[i].to) begin miscompares++; $display("[TB] FAIL timeout_flag[%0d]: got %b want %b", i, hif.o_mem_timeout, rows[i].to); end
      bump(rows[i].exp);
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_flush();
    set_idle();
    hif.i_ex_Redirect = 1'b1;
    @(negedge clk);
    vectors++;
    if (ctl !== C_REDIR) begin miscompares++; $display("[TB] FAIL mid_flush_redir: got %b want %b", ctl, C_REDIR); end
    next_cycle();
    hif.i_ex_Redirect = 1'b0;
    #2;
    vectors++;
    if (ctl !== C_FLUSH) begin miscompares++; $display("[TB] FAIL mid_flush_flush: got %b want %b", ctl, C_FLUSH); end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (ctl !== C_NONE) begin miscompares++; $display("[TB] FAIL mid_flush_rst_ctl: got %b want %b", ctl, C_NONE); end
    vectors++;
    if (hif.o_stall_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL mid_flush_rst_cnt: got %h want 0000", hif.o_stall_cnt); end
    vectors++;
    if (hif.o_mem_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_flush_rst_timeout: got %b want 0", hif.o_mem_timeout); end
    exp_cnt = 16'd0;
    next_cycle();
    @(negedge clk);
    reset_n = 1'b1;
    next_cycle();
    @(negedge clk);
    vectors++;
    if (ctl !== C_NONE) begin miscompares++; $display("[TB] FAIL mid_flush_after_release: got %b want %b", ctl, C_NONE); end
    next_cycle();
    set_lu(5'd5);
    @(negedge clk);
    vectors++;
    if (ctl !== C_LU) begin miscompares++; $display("[TB] FAIL mid_flush_run_lu: got %b want %b", ctl, C_LU); end
    bump(C_LU);
    next_cycle();
  endtask

  task automatic test_stall_saturation();
    set_lu(5'd5);
    repeat (99) next_cycle();
    @(negedge clk);
    vectors++;
    if (hif.o_stall_cnt !== 16'd100) begin miscompares++; $display("[TB] FAIL sat_cnt_100: got %0d want 100", hif.o_stall_cnt); end
    repeat (65440) next_cycle();
    @(negedge clk);
    vectors++;
    if (hif.o_stall_cnt !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_cnt_max: got %h want ffff", hif.o_stall_cnt); end
    vectors++;
    if (ctl !== C_LU) begin miscompares++; $display("[TB] FAIL sat_ctl: got %b want %b", ctl, C_LU); end
    repeat (3) next_cycle();
    set_idle();
    next_cycle();
    @(negedge clk);
    vectors++;
    if (hif.o_stall_cnt !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL sat_no_wrap: got %h want ffff", hif.o_stall_cnt); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    exp_cnt     = 16'd0;
    reset_n     = 1'b0;
    set_idle();
    test_reset();
    test_load_use();
    test_mem_wait();
    test_redirect();
    test_priority();
    test_timeout();
    test_reset_mid_flush();
    test_stall_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter FLUSH_LEN, default 2, number of bubble cycles inserted into ID/EX per redirect (legal range 1..7).
REQ-002 Parameter MEM_TIMEOUT, default 255, maximum consecutive MEM_WAIT cycles before the error flag sets (legal range 1..65535).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 i_id_Rs1, i_id_Rs2  input  5 each  source register addresses of the instruction in ID.
REQ-006 i_id_UsesRs1, i_id_UsesRs2  input  1 each  ID instruction reads Rs1 / Rs2.
REQ-007 i_ex_RegDst  input  5  destination register of the instruction in EX.
REQ-008 i_ex_MemToReg, i_ex_RegWrEn  input  1 each  EX instruction is a load / writes a register.
REQ-009 i_ex_Redirect  input  1  taken branch or jump resolved in EX.
REQ-010 i_mem_Req, i_mem_Ready  input  1 each  data-memory access pending in MEM / memory completes this cycle.
REQ-011 o_if_stall, o_id_stall, o_ex_stall, o_mem_stall  output  1 each  hold the named stage register.
REQ-012 o_if_flush, o_id_flush  output  1 each  load a bubble (all control fields 0) into IF/ID or ID/EX.
REQ-013 o_pc_sel  output  1  PC takes the redirect target this cycle.
REQ-014 o_mem_timeout  output  1  sticky memory-timeout error.
REQ-015 o_stall_cnt  output  16  count of stall/bubble cycles.

Function
REQ-016 FSM states RUN, MEM_WAIT, FLUSH; control outputs combinational from state and inputs.
REQ-017 load_use = i_ex_MemToReg & i_ex_RegWrEn & (i_ex_RegDst!=0) & ((i_id_UsesRs1 & Rs1==RegDst) | (i_id_UsesRs2 & Rs2==RegDst)).
REQ-018 mem_block = i_mem_Req & ~i_mem_Ready.
REQ-019 Priority, highest first: mem_block, i_ex_Redirect, load_use.
REQ-020 RUN & mem_block: assert all four stalls the same cycle, no flush, no o_pc_sel; next MEM_WAIT; wait counter := 1.
REQ-021 MEM_WAIT: all four stalls asserted while mem_block; counter increments, saturating at 0xFFFF; i_ex_Redirect and load_use are ignored.
REQ-022 MEM_WAIT & i_mem_Ready: stalls deasserted that same cycle; next RUN; a redirect held in EX is serviced in the following cycle.
REQ-023 Wait counter reaching MEM_TIMEOUT sets o_mem_timeout; it stays set until reset, and the FSM keeps waiting.
REQ-024 RUN & i_ex_Redirect: o_pc_sel=1, o_if_flush=1, o_id_flush=1 for one cycle.
REQ-025 Redirect with FLUSH_LEN==1: stay in RUN.
REQ-026 Redirect with FLUSH_LEN>1: next FLUSH; flush counter := FLUSH_LEN-1.
REQ-027 FLUSH: o_if_flush=o_id_flush=1; counter decrements; exit to RUN after the cycle in which it reaches 1.
REQ-028 FLUSH & i_ex_Redirect: treat as a new redirect; o_pc_sel=1 and the counter reloads FLUSH_LEN-1.
REQ-029 FLUSH & mem_block: MEM_WAIT entry per REQ-020 takes precedence; the remaining flush cycles are discarded.
REQ-030 RUN & load_use (no higher event): o_if_stall=o_id_stall=1 and o_id_flush=1 for exactly that cycle; EX/MEM not stalled; no state change.
REQ-031 load_use with i_ex_RegDst==0: no stall.
REQ-032 o_stall_cnt increments on each cycle with o_id_stall|o_id_flush, saturates at 0xFFFF, and never wraps.

Reset
REQ-033 reset_n low asynchronously forces state RUN, both counters 0, o_mem_timeout 0, o_stall_cnt 0.
REQ-034 While reset_n is low, all stall, flush and o_pc_sel outputs are 0.
REQ-035 Reset asserted mid-MEM_WAIT or mid-FLUSH abandons the operation; the first cycle after release is RUN.

Verification
REQ-036 Scenario: EX load with RegDst=5, ID Rs2=5 with UsesRs2 -> one cycle of if/id stall plus id_flush; o_stall_cnt=1; the same case with RegDst=0 -> no stall.
REQ-037 Scenario: i_mem_Req=1 with Ready low for 3 cycles -> 3 cycles of all-stall, then release in the Ready cycle; return to RUN.
REQ-038 Scenario: Redirect with FLUSH_LEN=2 -> cycle0 pc_sel+flushes, cycle1 flushes only, cycle2 RUN with no flush; a second redirect in cycle1 -> pc_sel again and 2 further flush cycles.
REQ-039 Scenario: mem_block, Redirect and load_use asserted together -> only all-stall; the redirect is serviced the cycle after Ready.
REQ-040 Scenario: MEM_TIMEOUT=4 with Ready held low for 6 cycles -> o_mem_timeout rises at the 4th wait cycle and stays high after Ready.
REQ-041 Scenario: reset_n pulsed low mid-FLUSH -> outputs 0 immediately, RUN after release, all counters 0; o_stall_cnt forced to 0xFFFF saturates with no wrap.
